wb_writeback: RTL and testbench

- Write-side counterpart to the register-file read path: it drives the regfile write port (rf_write_en, rf_write_reg, rf_write_data).
- It merges two result sources onto one write port:
  - ALU/immediate results (add/addi/lui/auipc/jal link, ...), which arrive with no backpressure.
  - Load responses (lb/lh/lw/lbu/lhu), which use a valid/ready handshake.
- Load data are byte/halfword-extracted and extended before write. Loads queue in a small FIFO while the ALU holds the port.

---
 rtl/wb_pkg.sv | 50 +++++
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_writeback.sv | 134 +++++++++++++
 tb/tb_wb_writeback.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes,
// the queued writeback entry, and the load byte/halfword extraction function.
// No state; purely combinational helpers.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One pending register write.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Extraction result: extended data plus an illegal-funct3 flag.
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } ld_ext_t;

  // Picks the addressed byte/halfword out of the aligned word and extends it.
  // Illegal funct3 codes fall back to a full-word load and raise err.
  function automatic ld_ext_t load_extract(input logic [2:0]  funct3,
                                           input logic [1:0]  addr_lo,
                                           input logic [31:0] rdata);
    ld_ext_t     r;
    logic [7:0]  b;
    logic [15:0] h;
    b      = 8'(rdata >> {addr_lo, 3'b000});
    h      = 16'(rdata >> {addr_lo[1], 4'b0000});
    r.err  = 1'b0;
    r.data = rdata;
    case (funct3)
      F3_LB:   r.data = {{24{b[7]}}, b};
      F3_LBU:  r.data = {24'h0, b};
      F3_LH:   r.data = {{16{h[15]}}, h};
      F3_LHU:  r.data = {16'h0, h};
      F3_LW:   r.data = rdata;
      default: begin
        r.data = rdata;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
// Latency: a push is visible at the head the cycle after its edge; pop_dat is the current head.
// Backpressure: push is ignored when full and pop when empty; the owner must gate on full/empty.
// Ports: clk, rst (async active-low), push/push_dat, pop/pop_dat, full, empty, count.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_writeback.sv
// Regfile writeback: merges unthrottled ALU results with queued load responses onto one write port.
// Latency: ALU result on rf_* one cycle after it is presented; a load at least two cycles after acceptance.
// Backpressure: ALU always wins and is never stalled; loads wait in the FIFO, ld_ready drops when it is full.
// Ports: alu_* (valid/rd/data), ld_* (valid/ready handshake, rd, funct3, addr_lo, rdata),
//        rf_write_* (registered write port), ld_err (illegal funct3 pulse), fifo_count.
// Optional: define WB_PENDING_EN to add ld_pending[31:0], a per-register "load still queued" map.
module wb_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [2:0]             ld_funct3,
  input  logic [1:0]             ld_addr_lo,
  input  logic [XLEN-1:0]        ld_rdata,
  output logic                   rf_write_en,
  output logic [4:0]             rf_write_reg,
  output logic [XLEN-1:0]        rf_write_data,
  output logic                   ld_err,
`ifdef WB_PENDING_EN
  output logic [31:0]            ld_pending,
`endif
  output logic [$clog2(DEPTH):0] fifo_count
);

  wb_entry_t push_ent;
  wb_entry_t head_ent;
  wb_entry_t sel_ent;
  ld_ext_t   ext;
  logic      sel_vld;
  logic      ld_acc;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;

  // Ready comes from registered FIFO state only, and is held low during reset.
  assign ld_ready = rst & ~fifo_full;
  assign ld_acc   = ld_valid & ld_ready;

  // Extraction happens before enqueue so the FIFO only stores final write data.
  assign ext      = load_extract(ld_funct3, ld_addr_lo, ld_rdata);
  assign push_ent = '{rd: ld_rd, data: ext.data};

  // A FIFO entry is only popped on cycles the ALU leaves the port free.
  assign fifo_pop = ~alu_valid & ~fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_acc),
    .push_dat (push_ent),
    .pop      (fifo_pop),
    .pop_dat  (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    sel_vld = 1'b0;
    sel_ent = '0;
    if (alu_valid) begin
      sel_vld      = 1'b1;
      sel_ent.rd   = alu_rd;
      sel_ent.data = alu_data;
    end else if (!fifo_empty) begin
      sel_vld = 1'b1;
      sel_ent = head_ent;
    end
  end

  // x0 writes still consume their slot (and FIFO entry) but never strobe the regfile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_write_en   <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      ld_err        <= 1'b0;
    end else begin
      rf_write_en <= sel_vld & (sel_ent.rd != 5'd0);
      if (sel_vld) begin
        rf_write_reg  <= sel_ent.rd;
        rf_write_data <= sel_ent.data;
      end
      ld_err <= ld_acc & ext.err;
    end
  end

`ifdef WB_PENDING_EN
  // Saturating 2-bit occupancy per register. A push and pop of the same
  // register in one cycle cancel; x0 is never tracked.
  logic [1:0]  pend_cnt [32];
  logic [31:0] pend_inc;
  logic [31:0] pend_dec;

  always_comb begin
    pend_inc = '0;
    pend_dec = '0;
    if (ld_acc)   pend_inc[ld_rd]       = 1'b1;
    if (fifo_pop) pend_dec[head_ent.rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) pend_cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        case ({pend_inc[i], pend_dec[i]})
          2'b10:   if (pend_cnt[i] != 2'd3) pend_cnt[i] <= pend_cnt[i] + 2'd1;
          2'b01:   if (pend_cnt[i] != 2'd0) pend_cnt[i] <= pend_cnt[i] - 2'd1;
          default: pend_cnt[i] <= pend_cnt[i];
        endcase
      end
    end
  end

  always_comb begin
    ld_pending = '0;
    for (int i = 1; i < 32; i++) ld_pending[i] = (pend_cnt[i] != 2'd0);
  end
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// Bench for wb_writeback: directed literal cases plus randomized traffic,
// all checked every cycle against a queue-based model of the writeback rules.
module tb_wb_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alu_valid;
  logic [4:0]             alu_rd;
  logic [31:0]            alu_data;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [4:0]             ld_rd;
  logic [2:0]             ld_funct3;
  logic [1:0]             ld_addr_lo;
  logic [31:0]            ld_rdata;
  logic                   rf_write_en;
  logic [4:0]             rf_write_reg;
  logic [31:0]            rf_write_data;
  logic                   ld_err;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_PENDING_EN
  logic [31:0]            ld_pending;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  wb_writeback #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_rd         (ld_rd),
    .ld_funct3     (ld_funct3),
    .ld_addr_lo    (ld_addr_lo),
    .ld_rdata      (ld_rdata),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .ld_err        (ld_err),
`ifdef WB_PENDING_EN
    .ld_pending    (ld_pending),
`endif
    .fifo_count    (fifo_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] v;
    int          sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = int'(a) * 8;
        v  = (d >> sh) & 32'h0000_00FF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        sh = a[1] ? 16 : 0;
        v  = (d >> sh) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic bit ref_illegal(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  wb_entry_t   q[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_reg  = '0;
  logic [31:0] m_data = '0;
  logic        m_err  = 1'b0;
  int          pc[32];

  always @(posedge clk or negedge rst) begin
    wb_entry_t s;
    wb_entry_t n;
    bit        sel;
    bit        popped;
    bit        acc;
    if (!rst) begin
      q.delete();
      m_en   = 1'b0;
      m_reg  = '0;
      m_data = '0;
      m_err  = 1'b0;
      for (int r = 0; r < 32; r++) pc[r] = 0;
    end else begin
      acc    = ld_valid && (q.size() != DEPTH);
      sel    = 1'b0;
      popped = 1'b0;
      s      = '0;
      if (alu_valid) begin
        sel    = 1'b1;
        s.rd   = alu_rd;
        s.data = alu_data;
      end else if (q.size() > 0) begin
        s      = q.pop_front();
        sel    = 1'b1;
        popped = 1'b1;
      end
      n.rd   = ld_rd;
      n.data = ref_extract(ld_funct3, ld_addr_lo, ld_rdata);
      if (acc) q.push_back(n);
      m_en = sel && (s.rd != 5'd0);
      if (sel) begin
        m_reg  = s.rd;
        m_data = s.data;
      end
      m_err = acc && ref_illegal(ld_funct3);
      if (!(acc && popped && n.rd == s.rd)) begin
        if (acc && n.rd != 0 && pc[n.rd] < 3) pc[n.rd]++;
        if (popped && s.rd != 0 && pc[s.rd] > 0) pc[s.rd]--;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("ld_ready", 32'(ld_ready), 32'(rst && (q.size() != DEPTH)));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("rf_write_en", 32'(rf_write_en), 32'(m_en));
      if (m_en) begin
        chk("rf_write_reg", 32'(rf_write_reg), 32'(m_reg));
        chk("rf_write_data", rf_write_data, m_data);
      end
      chk("ld_err", 32'(ld_err), 32'(m_err));
`ifdef WB_PENDING_EN
      begin
        logic [31:0] ep;
        ep = '0;
        for (int r = 1; r < 32; r++) ep[r] = (pc[r] > 0);
        chk("ld_pending", ld_pending, ep);
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic offer(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                       input logic [31:0] d);
    int n;
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = a;
    ld_rdata   = d;
    n = 0;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) chk("offer_timeout", 32'(ld_ready), 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Single load with idle ALU and empty FIFO; checks the err pulse and the final write.
  task automatic do_load(input string nm, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic exp_err);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = a;
    ld_rdata   = d;
    @(negedge clk);
    ld_valid = 1'b0;
    chk({nm, "_err"}, 32'(ld_err), 32'(exp_err));
    chk({nm, "_en_early"}, 32'(rf_write_en), 32'd0);
    @(negedge clk);
    chk({nm, "_en"}, 32'(rf_write_en), 32'd1);
    chk({nm, "_reg"}, 32'(rf_write_reg), 32'(rd));
    chk({nm, "_data"}, rf_write_data, exp_data);
  endtask

  initial begin
    logic [4:0] exp_regs [6];
    bit         acc_now;
    int         idx;

    rst        = 1'b0;
    alu_valid  = 1'b0;
    alu_rd     = '0;
    alu_data   = '0;
    ld_valid   = 1'b0;
    ld_rd      = '0;
    ld_funct3  = '0;
    ld_addr_lo = '0;
    ld_rdata   = '0;

    // Model pins: hand-computed extraction results.
    chk("model_lb", ref_extract(F3_LB, 2'd2, 32'h1280_3456), 32'hFFFF_FF80);
    chk("model_lhu", ref_extract(F3_LHU, 2'd3, 32'hBEEF_0000), 32'h0000_BEEF);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_en", 32'(rf_write_en), 32'd0);
    chk("rst_reg", 32'(rf_write_reg), 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(ld_ready), 32'd1);

    // Extraction cases.
    do_load("lb", 5'd9, F3_LB, 2'd2, 32'h1280_3456, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 5'd9, F3_LBU, 2'd2, 32'h1280_3456, 32'h0000_0080, 1'b0);
    do_load("lhu", 5'd10, F3_LHU, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, 1'b0);
    do_load("lh", 5'd11, F3_LH, 2'd1, 32'h1234_8001, 32'hFFFF_8001, 1'b0);
    do_load("ill", 5'd12, 3'b011, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    @(negedge clk);
    chk("ill_err_oneshot", 32'(ld_err), 32'd0);

    // ALU to x0 is suppressed.
    alu_valid = 1'b1;
    alu_rd    = 5'd0;
    alu_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    alu_valid = 1'b0;
    chk("x0_en", 32'(rf_write_en), 32'd0);

    // ALU priority over a queued load.
    ld_valid   = 1'b1;
    ld_rd      = 5'd5;
    ld_funct3  = F3_LW;
    ld_addr_lo = 2'd0;
    ld_rdata   = 32'h0000_0055;
    @(negedge clk);
    ld_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'd6;
      alu_data  = 32'h600 + 32'(k);
      @(negedge clk);
      chk("prio_alu_reg", 32'(rf_write_reg), 32'd6);
      chk("prio_alu_data", rf_write_data, 32'h600 + 32'(k));
    end
    alu_valid = 1'b0;
    @(negedge clk);
    chk("prio_ld_en", 32'(rf_write_en), 32'd1);
    chk("prio_ld_reg", 32'(rf_write_reg), 32'd5);
    chk("prio_ld_data", rf_write_data, 32'h55);

    // Full FIFO and backpressure.
    alu_valid = 1'b1;
    alu_rd    = 5'd10;
    alu_data  = 32'h1111_0000;
    for (int i = 0; i < 4; i++) offer(5'(11 + i), F3_LW, 2'd0, 32'(32'hA0 + i));
    ld_valid = 1'b1;
    ld_rd    = 5'd15;
    ld_rdata = 32'hA4;
    @(negedge clk);
    chk("full_ready", 32'(ld_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    alu_valid = 1'b0;
    exp_regs  = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};
    idx = 0;
    for (int j = 0; j < 6; j++) begin
      acc_now = ld_valid && ld_ready;
      @(negedge clk);
      chk("drain_en", 32'(rf_write_en), 32'd1);
      chk("drain_reg", 32'(rf_write_reg), 32'(exp_regs[j]));
      if (acc_now) begin
        idx++;
        if (idx == 1) begin
          ld_rd    = 5'd16;
          ld_rdata = 32'hA5;
        end else begin
          ld_valid = 1'b0;
        end
      end
    end
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with loads queued.
    alu_valid = 1'b1;
    alu_rd    = 5'd20;
    for (int i = 0; i < 3; i++) offer(5'(21 + i), F3_LW, 2'd0, 32'(i));
    @(posedge clk);
    #2 rst = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("midrst_en", 32'(rf_write_en), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_ready", 32'(ld_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_write", 32'(rf_write_en), 32'd0);
    end
    chk("post_rst_ready", 32'(ld_ready), 32'd1);

`ifdef WB_PENDING_EN
    alu_valid = 1'b1;
    alu_rd    = 5'd21;
    offer(5'd7, F3_LW, 2'd0, 32'h7);
    offer(5'd7, F3_LW, 2'd0, 32'h77);
    chk("pend7_two", 32'(ld_pending[7]), 32'd1);
    alu_valid = 1'b0;
    @(negedge clk);
    chk("pend7_one", 32'(ld_pending[7]), 32'd1);
    @(negedge clk);
    chk("pend7_zero", 32'(ld_pending[7]), 32'd0);
    repeat (2) @(negedge clk);
`endif

    // Randomized traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      alu_valid  = ($urandom_range(0, 99) < 40);
      alu_rd     = 5'($urandom);
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 99) < 60);
      ld_rd      = 5'($urandom_range(0, 8));
      ld_funct3  = 3'($urandom);
      ld_addr_lo = 2'($urandom);
      ld_rdata   = $urandom;
      if (i == 1500) begin
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    repeat (10) @(negedge clk);
    chk("final_empty", 32'(fifo_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
